// File: rtl/mem_stage_lsu_if.sv
// Data-bus interface between the miniRV MEM stage (master) and the data
// memory or interconnect (slave). Single outstanding request: the master
// holds bus_req and the request fields stable until the slave pulses bus_ack.
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_wstrb,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_wstrb,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// miniRV MEM stage load/store unit.
// Sits between EX/MEM and MEM/WB. Non-memory instructions pass through in a
// single cycle; loads and stores go through a three-state FSM
// (IDLE -> BUSY -> DONE) that drives a single-outstanding req/ack bus, stalls
// the front of the pipeline, and hands MEM/WB a bubble until the access ends.
// Optional feature: define MISALIGN_CHK_EN to suppress misaligned accesses
// and flag them on misalign_err instead of issuing them on the bus.
module mem_stage_lsu (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst_n,
  // EX/MEM side
  input  logic                   mem_rd_MEM_in,
  input  logic                   mem_wr_MEM_in,
  input  logic [1:0]             mem_size_MEM_in,
  input  logic                   mem_uns_MEM_in,
  input  logic [31:0]            alu_MEM_in,
  input  logic [31:0]            rs2_MEM_in,
  input  logic [4:0]             wR_MEM_in,
  input  logic                   rf_we_MEM_in,
  input  logic [31:0]            pc_MEM_in,
  // MEM/WB side
  output logic [4:0]             wR_MEM_out,
  output logic                   rf_we_MEM_out,
  output logic [31:0]            wD_MEM_out,
  output logic [31:0]            pc_MEM_out,
  // Pipeline control
  output logic                   stall_MEM,
  // Data bus
  mem_stage_lsu_if.master        bus,
  output logic                   misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] rdata_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_wstrb_q;

  logic [31:0] bus_wdata_d;
  logic [3:0]  bus_wstrb_d;
  logic [31:0] load_data;

  logic mem_op;
  logic is_byte;
  logic is_half;
  logic is_word;
  logic suppress;
  logic start;

  assign mem_op  = mem_rd_MEM_in | mem_wr_MEM_in;
  assign is_byte = (mem_size_MEM_in == 2'b00);
  assign is_half = (mem_size_MEM_in == 2'b01);
  // Size 11 is handled as a word access.
  assign is_word = mem_size_MEM_in[1];

`ifdef MISALIGN_CHK_EN
  logic mis;
  assign mis      = (is_half & alu_MEM_in[0]) | (is_word & (alu_MEM_in[1:0] != 2'b00));
  // A misaligned op never reaches the bus; it spends one cycle in MEM as a flagged bubble.
  assign suppress = mem_op & mis;
`else
  // Without the check, misaligned accesses go out using the plain lane rules.
  assign suppress = 1'b0;
`endif

  // An access starts only from IDLE; the caller qualifies with the state.
  assign start = mem_op & ~suppress;

  // Store lane replication and byte strobes for the access about to be issued.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    bus_wdata_d = 32'h0;
    bus_wstrb_d = 4'b0000;
    if (mem_wr_MEM_in) begin
      if (is_byte) begin
        bus_wdata_d = {4{rs2_MEM_in[7:0]}};
        bus_wstrb_d = 4'b0001 << alu_MEM_in[1:0];
      end else if (is_half) begin
        bus_wdata_d = {2{rs2_MEM_in[15:0]}};
        bus_wstrb_d = alu_MEM_in[1] ? 4'b1100 : 4'b0011;
      end else begin
        bus_wdata_d = rs2_MEM_in;
        bus_wstrb_d = 4'b1111;
      end
    end
  end

  // Lane extraction and sign/zero extension of the captured load word.
  always_comb begin
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    ld_byte = 8'h0;
    case (alu_MEM_in[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = alu_MEM_in[1] ? rdata_q[31:16] : rdata_q[15:0];
    if (is_byte) begin
      load_data = mem_uns_MEM_in ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (is_half) begin
      load_data = mem_uns_MEM_in ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end else begin
      load_data = rdata_q;
    end
  end

  // Access FSM with registered bus outputs; request fields are latched on entry to BUSY.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= S_IDLE;
      rdata_q     <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_wstrb_q <= 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_BUSY;
            bus_req_q   <= 1'b1;
            bus_we_q    <= mem_wr_MEM_in;
            bus_addr_q  <= {alu_MEM_in[31:2], 2'b00};
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
          end
        end
        S_BUSY: begin
          // No timeout: the stage waits on the slave indefinitely.
          if (bus.bus_ack) begin
            state_q     <= S_DONE;
            rdata_q     <= bus.bus_rdata;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'b0000;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_wstrb = bus_wstrb_q;

  // Stall, writeback enable and writeback data seen by MEM/WB.
  always_comb begin
    stall_MEM     = 1'b0;
    rf_we_MEM_out = 1'b0;
    wD_MEM_out    = alu_MEM_in;
    case (state_q)
      S_IDLE: begin
        stall_MEM     = start;
        // Stalled or suppressed ops hand MEM/WB a bubble.
        rf_we_MEM_out = rf_we_MEM_in & ~mem_op;
      end
      S_BUSY: begin
        stall_MEM = 1'b1;
      end
      S_DONE: begin
        rf_we_MEM_out = rf_we_MEM_in;
        if (mem_rd_MEM_in) begin
          wD_MEM_out = load_data;
        end
      end
      default: begin
        stall_MEM = 1'b0;
      end
    endcase
    // Keep the pipeline free and MEM/WB quiet while reset is held.
    if (!cpu_rst_n) begin
      stall_MEM     = 1'b0;
      rf_we_MEM_out = 1'b0;
    end
  end

`ifdef MISALIGN_CHK_EN
  assign misalign_err = cpu_rst_n & (state_q == S_IDLE) & suppress;
`else
  assign misalign_err = 1'b0;
`endif

  assign wR_MEM_out = wR_MEM_in;
  assign pc_MEM_out = pc_MEM_in;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: table-driven pass-through and
// load/store vectors plus hand-written reset-in-BUSY and misalignment
// sequences. Inputs change 1 ns after the rising edge; outputs are sampled
// on the falling edge.
module tb_mem_stage_lsu;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst_n = 1'b0;
  logic        mem_rd_MEM_in, mem_wr_MEM_in, mem_uns_MEM_in, rf_we_MEM_in;
  logic [1:0]  mem_size_MEM_in;
  logic [31:0] alu_MEM_in, rs2_MEM_in, pc_MEM_in;
  logic [4:0]  wR_MEM_in;
  logic [4:0]  wR_MEM_out;
  logic        rf_we_MEM_out, stall_MEM, misalign_err;
  logic [31:0] wD_MEM_out, pc_MEM_out;

  mem_stage_lsu_if bus_if();

  always #5 cpu_clk = ~cpu_clk;

  mem_stage_lsu dut (
    .cpu_clk         (cpu_clk),
    .cpu_rst_n       (cpu_rst_n),
    .mem_rd_MEM_in   (mem_rd_MEM_in),
    .mem_wr_MEM_in   (mem_wr_MEM_in),
    .mem_size_MEM_in (mem_size_MEM_in),
    .mem_uns_MEM_in  (mem_uns_MEM_in),
    .alu_MEM_in      (alu_MEM_in),
    .rs2_MEM_in      (rs2_MEM_in),
    .wR_MEM_in       (wR_MEM_in),
    .rf_we_MEM_in    (rf_we_MEM_in),
    .pc_MEM_in       (pc_MEM_in),
    .wR_MEM_out      (wR_MEM_out),
    .rf_we_MEM_out   (rf_we_MEM_out),
    .wD_MEM_out      (wD_MEM_out),
    .pc_MEM_out      (pc_MEM_out),
    .stall_MEM       (stall_MEM),
    .bus             (bus_if.master),
    .misalign_err    (misalign_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] alu;
    logic        rf_we;
    logic [4:0]  wr;
    logic [31:0] pc;
    logic [31:0] exp_wd;
    logic        exp_rf_we;
  } alu_vec_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waits;
    logic        rf_we;
    logic [31:0] exp_wd;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } mem_vec_t;

  task automatic idle_inputs();
    mem_rd_MEM_in   = 1'b0;
    mem_wr_MEM_in   = 1'b0;
    mem_size_MEM_in = 2'b00;
    mem_uns_MEM_in  = 1'b0;
    alu_MEM_in      = 32'h0;
    rs2_MEM_in      = 32'h0;
    wR_MEM_in       = 5'd0;
    rf_we_MEM_in    = 1'b0;
    pc_MEM_in       = 32'h0;
  endtask

  // Runs one memory op starting in an IDLE cycle; called 1 ns after a rising edge
  // and returns 1 ns after the edge that takes the FSM back to IDLE.
  task automatic run_mem(input string tag, input mem_vec_t v);
    int stalls;
    stalls          = 0;
    mem_rd_MEM_in   = v.rd;
    mem_wr_MEM_in   = v.wr;
    mem_size_MEM_in = v.size;
    mem_uns_MEM_in  = v.uns;
    alu_MEM_in      = v.addr;
    rs2_MEM_in      = v.rs2;
    wR_MEM_in       = 5'd9;
    rf_we_MEM_in    = v.rf_we;
    pc_MEM_in       = 32'h0000_1000;
    @(negedge cpu_clk);
    check({tag, " idle stall"}, stall_MEM, 1'b1);
    check({tag, " idle req"}, bus_if.bus_req, 1'b0);
    check({tag, " idle rf_we"}, rf_we_MEM_out, 1'b0);
    check({tag, " idle misalign"}, misalign_err, 1'b0);
    stalls += int'(stall_MEM);
    @(posedge cpu_clk); #1;
    for (int w = 0; w <= v.waits; w++) begin
      bus_if.bus_ack   = (w == v.waits);
      bus_if.bus_rdata = (w == v.waits) ? v.rdata : 32'hFFFF_FFFF;
      @(negedge cpu_clk);
      check($sformatf("%s busy%0d req", tag, w), bus_if.bus_req, 1'b1);
      check($sformatf("%s busy%0d stall", tag, w), stall_MEM, 1'b1);
      check($sformatf("%s busy%0d rf_we", tag, w), rf_we_MEM_out, 1'b0);
      check($sformatf("%s busy%0d addr", tag, w), bus_if.bus_addr, v.exp_addr);
      check($sformatf("%s busy%0d we", tag, w), bus_if.bus_we, v.wr);
      if (v.wr) begin
        check($sformatf("%s busy%0d wdata", tag, w), bus_if.bus_wdata, v.exp_wdata);
        check($sformatf("%s busy%0d wstrb", tag, w), bus_if.bus_wstrb, v.exp_wstrb);
      end
      stalls += int'(stall_MEM);
      @(posedge cpu_clk); #1;
    end
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    @(negedge cpu_clk);
    check({tag, " done stall"}, stall_MEM, 1'b0);
    check({tag, " done req"}, bus_if.bus_req, 1'b0);
    check({tag, " done addr"}, bus_if.bus_addr, 32'h0);
    check({tag, " done rf_we"}, rf_we_MEM_out, v.rf_we);
    check({tag, " done wR"}, wR_MEM_out, 5'd9);
    check({tag, " done pc"}, pc_MEM_out, 32'h0000_1000);
    if (v.rd) check({tag, " done wD"}, wD_MEM_out, v.exp_wd);
    check({tag, " stall cycles"}, stalls, v.waits + 2);
    @(posedge cpu_clk); #1;
  endtask

  // Hard stop in case something in the sequence hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    alu_vec_t alu_tab[3];
    mem_vec_t mem_tab[15];
    mem_vec_t v;

    // {alu, rf_we, wR, pc, exp_wd, exp_rf_we}
    alu_tab[0] = '{32'h0000_1234, 1'b1, 5'd1,  32'h0000_0040, 32'h0000_1234, 1'b1};
    alu_tab[1] = '{32'hFFFF_0001, 1'b0, 5'd31, 32'h8000_0000, 32'hFFFF_0001, 1'b0};
    alu_tab[2] = '{32'h0000_0103, 1'b1, 5'd17, 32'h0000_0ABC, 32'h0000_0103, 1'b1};

    // {rd, wr, size, uns, addr, rs2, rdata, waits, rf_we, exp_wd, exp_addr, exp_wdata, exp_wstrb}
    mem_tab[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b1, 32'hDEADBEEF, 32'h100, 32'h0, 4'b0000};
    mem_tab[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233, 0, 1'b1, 32'hFFFFFF80, 32'h100, 32'h0, 4'b0000};
    mem_tab[2]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233, 0, 1'b1, 32'h00000080, 32'h100, 32'h0, 4'b0000};
    mem_tab[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80112233, 0, 1'b1, 32'hFFFF8011, 32'h100, 32'h0, 4'b0000};
    mem_tab[4]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80112233, 0, 1'b1, 32'h00008011, 32'h100, 32'h0, 4'b0000};
    mem_tab[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h80112233, 1, 1'b1, 32'h00002233, 32'h100, 32'h0, 4'b0000};
    mem_tab[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h80112233, 0, 1'b1, 32'h00000022, 32'h100, 32'h0, 4'b0000};
    mem_tab[7]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h104, 32'h0, 32'h80000000, 0, 1'b1, 32'h80000000, 32'h104, 32'h0, 4'b0000};
    mem_tab[8]  = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h108, 32'h0, 32'h0BADF00D, 0, 1'b1, 32'h0BADF00D, 32'h108, 32'h0, 4'b0000};
    mem_tab[9]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h123456AB, 32'h0, 0, 1'b0, 32'h0, 32'h200, 32'hABABABAB, 4'b0010};
    mem_tab[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'hCAFEBEEF, 32'h0, 1, 1'b0, 32'h0, 32'h200, 32'hBEEFBEEF, 4'b1100};
    mem_tab[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h200, 32'h0000BEEF, 32'h0, 0, 1'b0, 32'h0, 32'h200, 32'hBEEFBEEF, 4'b0011};
    mem_tab[12] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'h11223344, 32'h0, 0, 1'b0, 32'h0, 32'h300, 32'h11223344, 4'b1111};
    mem_tab[13] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h203, 32'h0000005A, 32'h0, 3, 1'b0, 32'h0, 32'h200, 32'h5A5A5A5A, 4'b1000};
    mem_tab[14] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h80112233, 0, 1'b1, 32'h00000011, 32'h100, 32'h0, 4'b0000};

    idle_inputs();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;

    // Reset state.
    @(negedge cpu_clk);
    check("rst stall", stall_MEM, 1'b0);
    check("rst rf_we", rf_we_MEM_out, 1'b0);
    check("rst req", bus_if.bus_req, 1'b0);
    check("rst we", bus_if.bus_we, 1'b0);
    check("rst addr", bus_if.bus_addr, 32'h0);
    check("rst wdata", bus_if.bus_wdata, 32'h0);
    check("rst wstrb", bus_if.bus_wstrb, 4'b0000);
    check("rst misalign", misalign_err, 1'b0);
    @(posedge cpu_clk); #1;
    cpu_rst_n = 1'b1;

    // Non-memory pass-through, one cycle each.
    for (int i = 0; i < 3; i++) begin
      alu_MEM_in   = alu_tab[i].alu;
      rf_we_MEM_in = alu_tab[i].rf_we;
      wR_MEM_in    = alu_tab[i].wr;
      pc_MEM_in    = alu_tab[i].pc;
      @(negedge cpu_clk);
      check($sformatf("alu%0d wD", i), wD_MEM_out, alu_tab[i].exp_wd);
      check($sformatf("alu%0d rf_we", i), rf_we_MEM_out, alu_tab[i].exp_rf_we);
      check($sformatf("alu%0d wR", i), wR_MEM_out, alu_tab[i].wr);
      check($sformatf("alu%0d pc", i), pc_MEM_out, alu_tab[i].pc);
      check($sformatf("alu%0d stall", i), stall_MEM, 1'b0);
      check($sformatf("alu%0d req", i), bus_if.bus_req, 1'b0);
      @(posedge cpu_clk); #1;
    end

    // Loads and stores, issued back to back.
    for (int i = 0; i < 15; i++) begin
      run_mem($sformatf("mem%0d", i), mem_tab[i]);
    end
    idle_inputs();

    // Reset asserted while an access is in BUSY.
    mem_rd_MEM_in   = 1'b1;
    mem_size_MEM_in = 2'b10;
    alu_MEM_in      = 32'h100;
    rf_we_MEM_in    = 1'b1;
    @(posedge cpu_clk); #1;
    @(negedge cpu_clk);
    check("rstbusy req before", bus_if.bus_req, 1'b1);
    #1;
    cpu_rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rstbusy req dropped", bus_if.bus_req, 1'b0);
    check("rstbusy stall", stall_MEM, 1'b0);
    check("rstbusy addr", bus_if.bus_addr, 32'h0);
    @(posedge cpu_clk); #1;
    cpu_rst_n        = 1'b1;
    alu_MEM_in       = 32'h0000_0055;
    rf_we_MEM_in     = 1'b1;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h1234_5678;
    @(negedge cpu_clk);
    check("spurious ack stall", stall_MEM, 1'b0);
    check("spurious ack req", bus_if.bus_req, 1'b0);
    check("spurious ack rf_we", rf_we_MEM_out, 1'b1);
    check("spurious ack wD", wD_MEM_out, 32'h0000_0055);
    @(posedge cpu_clk); #1;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    @(negedge cpu_clk);
    check("after spurious stall", stall_MEM, 1'b0);
    check("after spurious rf_we", rf_we_MEM_out, 1'b1);
    @(posedge cpu_clk); #1;
    run_mem("post-reset lw", mem_tab[0]);
    idle_inputs();

    // Misaligned word load from 0x102.
`ifdef MISALIGN_CHK_EN
    mem_rd_MEM_in   = 1'b1;
    mem_size_MEM_in = 2'b10;
    alu_MEM_in      = 32'h102;
    rf_we_MEM_in    = 1'b1;
    @(negedge cpu_clk);
    check("mis lw err", misalign_err, 1'b1);
    check("mis lw stall", stall_MEM, 1'b0);
    check("mis lw req", bus_if.bus_req, 1'b0);
    check("mis lw rf_we", rf_we_MEM_out, 1'b0);
    @(posedge cpu_clk); #1;
    idle_inputs();
    @(negedge cpu_clk);
    check("mis lw err cleared", misalign_err, 1'b0);
    check("mis lw no access", bus_if.bus_req, 1'b0);
    check("mis lw no stall", stall_MEM, 1'b0);
    @(posedge cpu_clk); #1;
`else
    v = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D, 32'h100, 32'h0, 4'b0000};
    run_mem("mis lw", v);
    v = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h203, 32'h0000A55A, 32'h0, 0, 1'b0, 32'h0, 32'h200, 32'hA55AA55A, 4'b1100};
    run_mem("mis sh", v);
    idle_inputs();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
